// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and receiver FSM encoding.
package vga_timing_pkg;

  localparam int H_ACTIVE_NOM    = 640;
  localparam int H_SYNC_NOM      = 96;
  localparam int H_BP_NOM        = 48;
  localparam int H_TOTAL_NOM     = 800;
  localparam int V_ACTIVE_NOM    = 480;
  localparam int V_SYNC_NOM      = 2;
  localparam int V_BP_NOM        = 33;
  localparam int V_TOTAL_NOM     = 525;
  localparam logic SYNC_POL_NOM  = 1'b0;
  localparam int LOCK_FRAMES_NOM = 2;

  // Wide enough for a saturated horizontal count of 2*H_TOTAL.
  localparam int CNT_W = 12;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } rx_state_t;

endpackage

// File: rtl/vga_sync_edge.sv
// Sync input register: normalises polarity to asserted=1 and flags leading/trailing edges.
module vga_sync_edge
  import vga_timing_pkg::*;
#(
  parameter logic POL = SYNC_POL_NOM
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_in,
  output logic asserted,
  output logic lead,
  output logic trail
);

  logic s_p0;
  logic s_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_p0 <= 1'b0;
      s_p1 <= 1'b0;
    end else begin
      s_p0 <= (sync_in == POL);
      s_p1 <= s_p0;
    end
  end

  assign asserted = s_p0;
  assign lead     = s_p0 & ~s_p1;
  assign trail    = ~s_p0 & s_p1;

endmodule

// File: rtl/vga_rx_timing.sv
// Receive-side VGA timing recovery: measures line/frame geometry, locks, emits pixel coordinates.
// Define VGA_RX_CRC_EN to add a per-frame CRC-16-CCITT of active pixels (frame_crc, crc_valid).
module vga_rx_timing
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE    = H_ACTIVE_NOM,
  parameter int   H_SYNC      = H_SYNC_NOM,
  parameter int   H_BP        = H_BP_NOM,
  parameter int   H_TOTAL     = H_TOTAL_NOM,
  parameter int   V_ACTIVE    = V_ACTIVE_NOM,
  parameter int   V_SYNC      = V_SYNC_NOM,
  parameter int   V_BP        = V_BP_NOM,
  parameter int   V_TOTAL     = V_TOTAL_NOM,
  parameter logic SYNC_POL    = SYNC_POL_NOM,
  parameter int   LOCK_FRAMES = LOCK_FRAMES_NOM
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [2:0]  rgb,
  output logic        locked,
  output logic        de,
  output logic [9:0]  px_x,
  output logic [9:0]  px_y,
  output logic [2:0]  rgb_out,
  output logic        frame_start,
  output logic        h_err,
  output logic        v_err,
  output logic [7:0]  err_cnt
`ifdef VGA_RX_CRC_EN
  ,
  output logic [15:0] frame_crc,
  output logic        crc_valid
`endif
);

  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] HSAT_C  = CNT_W'(2 * H_TOTAL);
  localparam logic [CNT_W-1:0] HTOT_C  = CNT_W'(H_TOTAL);
  localparam logic [CNT_W-1:0] HSYNC_C = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] VTOT_C  = CNT_W'(V_TOTAL);
  localparam logic [CNT_W-1:0] VSYNC_C = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] X0_C    = CNT_W'(H_SYNC + H_BP);
  localparam logic [CNT_W-1:0] XEND_C  = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CNT_W-1:0] Y0_C    = CNT_W'(V_SYNC + V_BP);
  localparam logic [CNT_W-1:0] YEND_C  = CNT_W'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [3:0]       LOCK_C  = 4'(LOCK_FRAMES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + ONE_C;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic             hs_as, hs_lead, hs_trail;
  logic             vs_as, vs_lead, vs_trail;
  logic [2:0]       rgb_p0;
  logic [CNT_W-1:0] hcnt_q, vline_q, flen_q, vw_q;
  logic [CNT_W-1:0] hcnt_c, vline_c, flen_chk, hs_one;
  logic             h_seen_q, frame_bad_q;
  logic [3:0]       good_q;
  rx_state_t        state_q;
  logic             loss_c, herr_c, verr_c, bad_frame_c, de_c;

  // Stage 1: sample pins, normalise sync polarity, find edges
  vga_sync_edge #(.POL(SYNC_POL)) u_hs (
    .clk(clk), .rst_n(rst_n), .sync_in(hsync),
    .asserted(hs_as), .lead(hs_lead), .trail(hs_trail)
  );

  vga_sync_edge #(.POL(SYNC_POL)) u_vs (
    .clk(clk), .rst_n(rst_n), .sync_in(vsync),
    .asserted(vs_as), .lead(vs_lead), .trail(vs_trail)
  );

  always_ff @(posedge clk) begin
    rgb_p0 <= rgb;
  end

  assign hs_one = {{(CNT_W-1){1'b0}}, hs_lead};

  always_comb begin
    hcnt_c   = hs_lead ? '0 : sat_inc(hcnt_q, HSAT_C);
    vline_c  = vs_lead ? '0 : (hs_lead ? sat_inc(vline_q, '1) : vline_q);
    flen_chk = flen_q + hs_one;
    loss_c   = ~hs_lead & (hcnt_q == HSAT_C - ONE_C);
    herr_c   = loss_c
             | (h_seen_q & hs_lead  & (hcnt_q + ONE_C != HTOT_C))
             | (h_seen_q & hs_trail & (hcnt_q + ONE_C != HSYNC_C));
    verr_c   = (state_q != SEARCH)
             & ((vs_lead & (flen_chk != VTOT_C)) | (vs_trail & (vw_q != VSYNC_C)));
    bad_frame_c = frame_bad_q | herr_c | verr_c;
    de_c     = (state_q == LOCKED) & ~hs_as
             & (hcnt_c >= X0_C) & (hcnt_c < XEND_C)
             & (vline_c >= Y0_C) & (vline_c < YEND_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q      <= '0;
      vline_q     <= '0;
      flen_q      <= '0;
      vw_q        <= '0;
      h_seen_q    <= 1'b0;
      frame_bad_q <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_c;
      vline_q <= vline_c;
      if (vs_lead)      flen_q <= '0;
      else if (hs_lead) flen_q <= sat_inc(flen_q, '1);
      // vsync width counts line starts seen while vsync is asserted, including the one on its lead.
      if (vs_lead)              vw_q <= hs_one;
      else if (vs_as & hs_lead) vw_q <= sat_inc(vw_q, '1);
      if (loss_c)       h_seen_q <= 1'b0;
      else if (hs_lead) h_seen_q <= 1'b1;
      if (vs_lead)                frame_bad_q <= 1'b0;
      else if (herr_c | verr_c)   frame_bad_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEARCH;
      good_q  <= '0;
      locked  <= 1'b0;
    end else if (loss_c) begin
      state_q <= SEARCH;
      good_q  <= '0;
      locked  <= 1'b0;
    end else begin
      case (state_q)
        SEARCH: if (vs_lead) begin
          state_q <= TRACK;
          good_q  <= '0;
        end
        TRACK: if (vs_lead) begin
          if (bad_frame_c) begin
            good_q <= '0;
          end else if (good_q + 4'd1 == LOCK_C) begin
            state_q <= LOCKED;
            good_q  <= '0;
            locked  <= 1'b1;
          end else begin
            good_q <= good_q + 4'd1;
          end
        end
        LOCKED: if (herr_c | verr_c) begin
          state_q <= TRACK;
          good_q  <= '0;
          locked  <= 1'b0;
        end
        default: begin
          state_q <= SEARCH;
          good_q  <= '0;
          locked  <= 1'b0;
        end
      endcase
    end
  end

  // Stage 2: registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de          <= 1'b0;
      px_x        <= '0;
      px_y        <= '0;
      rgb_out     <= '0;
      frame_start <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
      err_cnt     <= '0;
    end else begin
      de          <= de_c;
      px_x        <= de_c ? 10'(hcnt_c - X0_C) : '0;
      px_y        <= de_c ? 10'(vline_c - Y0_C) : '0;
      rgb_out     <= de_c ? rgb_p0 : '0;
      frame_start <= vs_lead;
      h_err       <= herr_c;
      v_err       <= verr_c;
      if (herr_c | verr_c) err_cnt <= sat_inc8(err_cnt);
    end
  end

`ifdef VGA_RX_CRC_EN
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    end
    return r;
  endfunction

  logic [15:0] crc_acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_acc_q <= 16'hFFFF;
      frame_crc <= '0;
      crc_valid <= 1'b0;
    end else begin
      crc_valid <= vs_lead & (state_q != SEARCH) & ~bad_frame_c;
      if (vs_lead) begin
        frame_crc <= crc_acc_q;
        crc_acc_q <= 16'hFFFF;
      end else if (de_c) begin
        crc_acc_q <= crc16_byte(crc_acc_q, {5'd0, rgb_p0});
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_rx_timing.sv
// Directed bench for vga_rx_timing using a reduced 14x9 raster so many frames fit in a short run.
module tb_vga_rx_timing;

  localparam int HA = 8, HS = 2, HB = 2, HT = 14;
  localparam int VA = 4, VS = 1, VB = 2, VT = 9;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       hsync = 1'b1;
  logic       vsync = 1'b1;
  logic [2:0] rgb = 3'd0;
  logic       locked, de, frame_start, h_err, v_err;
  logic [9:0] px_x, px_y;
  logic [2:0] rgb_out;
  logic [7:0] err_cnt;
`ifdef VGA_RX_CRC_EN
  logic [15:0] frame_crc;
  logic        crc_valid;
`endif

  vga_rx_timing #(
    .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT),
    .SYNC_POL(1'b0), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .locked(locked), .de(de), .px_x(px_x), .px_y(px_y), .rgb_out(rgb_out),
    .frame_start(frame_start), .h_err(h_err), .v_err(v_err), .err_cnt(err_cnt)
`ifdef VGA_RX_CRC_EN
    , .frame_crc(frame_crc), .crc_valid(crc_valid)
`endif
  );

  always #20 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_de = 0, n_herr = 0, n_verr = 0, n_fs = 0, n_pixbad = 0, n_crcv = 0;
  int max_x = 0, max_y = 0, lock_fs = -1;
  int const_rgb = -1;
  logic locked_d = 1'b0;
  int h0, v0, d0, f0;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Observes outputs once per cycle, well after the rising edge.
  always @(posedge clk) begin
    #5;
    if (h_err) n_herr++;
    if (v_err) n_verr++;
    if (frame_start) n_fs++;
`ifdef VGA_RX_CRC_EN
    if (crc_valid) n_crcv++;
`endif
    if (de) begin
      n_de++;
      if (int'(px_x) > max_x) max_x = int'(px_x);
      if (int'(px_y) > max_y) max_y = int'(px_y);
      if (px_x >= 10'(HA) || px_y >= 10'(VA)) n_pixbad++;
      else if (const_rgb < 0 && rgb_out != 3'(px_x + px_y)) n_pixbad++;
    end else if (px_x != 10'd0 || px_y != 10'd0 || rgb_out != 3'd0) begin
      n_pixbad++;
    end
    if (locked && !locked_d && lock_fs < 0) lock_fs = n_fs;
    locked_d = locked;
  end

  function automatic logic [2:0] pcol(input int l, input int p);
    int x, y;
    x = p - (HS + HB);
    y = l - (VS + VB);
    if (x >= 0 && x < HA && y >= 0 && y < VA)
      return (const_rgb >= 0) ? 3'(const_rgb) : 3'(x + y);
    return 3'b111;
  endfunction

  task automatic pix(input logic h, input logic v, input logic [2:0] c);
    @(negedge clk);
    hsync = ~h;
    vsync = ~v;
    rgb   = c;
  endtask

  task automatic gen_lines(input int first, input int last, input int long_line);
    for (int l = first; l < last; l++) begin
      int len;
      len = (l == long_line) ? HT + 1 : HT;
      for (int p = 0; p < len; p++) pix(p < HS, l < VS, pcol(l, p));
    end
  endtask

  task automatic frame();
    gen_lines(0, VT, -1);
  endtask

`ifdef VGA_RX_CRC_EN
  function automatic logic [15:0] crc_model(input int n, input logic [7:0] b);
    logic [15:0] r;
    r = 16'hFFFF;
    for (int k = 0; k < n; k++) begin
      r = r ^ {b, 8'h00};
      for (int j = 0; j < 8; j++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction
`endif

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_locked", locked, 0);
    chk("rst_de", de, 0);
    chk("rst_px_x", px_x, 0);
    chk("rst_rgb_out", rgb_out, 0);
    chk("rst_errs", {frame_start, h_err, v_err}, 0);
    chk("rst_err_cnt", err_cnt, 0);
    rst_n = 1'b1;

    // Initial acquisition: locked on the 3rd frame_start.
    h0 = n_herr; v0 = n_verr; f0 = n_fs;
    frame(); frame();
    chk("prelock_locked", locked, 0);
    chk("prelock_fs", n_fs - f0, 2);
    d0 = n_de;
    frame();
    chk("lock_locked", locked, 1);
    chk("lock_at_fs", lock_fs, 3);
    chk("frame_de_cnt", n_de - d0, HA * VA);
    chk("max_px_x", max_x, HA - 1);
    chk("max_px_y", max_y, VA - 1);
    chk("pixel_align", n_pixbad, 0);
    chk("clean_herr", n_herr - h0, 0);
    chk("clean_verr", n_verr - v0, 0);

    // One 15-pixel line.
    h0 = n_herr; v0 = n_verr;
    gen_lines(0, VT, 4);
    chk("long_herr", n_herr - h0, 1);
    chk("long_verr", n_verr - v0, 0);
    chk("long_locked", locked, 0);
    chk("long_err_cnt", err_cnt, 1);
    frame(); frame();
    chk("long_relock_wait", locked, 0);
    frame();
    chk("long_relock", locked, 1);

    // One 8-line frame.
    h0 = n_herr; v0 = n_verr;
    gen_lines(0, VT - 1, -1);
    chk("short_still_locked", locked, 1);
    frame();
    chk("short_verr", n_verr - v0, 1);
    chk("short_herr", n_herr - h0, 0);
    chk("short_locked", locked, 0);
    chk("short_err_cnt", err_cnt, 2);
    frame();
    chk("short_relock_wait", locked, 0);
    frame();
    chk("short_relock", locked, 1);

    // hsync held deasserted past 2*H_TOTAL.
    h0 = n_herr;
    repeat (2 * HT + 6) pix(1'b0, 1'b0, 3'b111);
    chk("loss_herr", n_herr - h0, 1);
    chk("loss_locked", locked, 0);
    chk("loss_state", int'(dut.state_q), 0);
    chk("loss_err_cnt", err_cnt, 3);

    h0 = n_herr;
    frame(); frame();
    chk("resync_wait", locked, 0);
    frame();
    chk("resync_locked", locked, 1);
    chk("resync_no_herr", n_herr - h0, 0);

    // Reset in the middle of active line 4.
    gen_lines(0, 4, -1);
    for (int p = 0; p <= 6; p++) pix(p < HS, 1'b0, pcol(4, p));
    chk("pre_rst_de", de, 1);
    chk("pre_rst_px_y", px_y, 1);
    chk("pre_rst_err_cnt", err_cnt, 3);
    rst_n = 1'b0;
    #1;
    chk("midrst_locked", locked, 0);
    chk("midrst_de", de, 0);
    chk("midrst_px_y", px_y, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    for (int p = 7; p <= 8; p++) pix(p < HS, 1'b0, pcol(4, p));
    rst_n = 1'b1;
    h0 = n_herr;
    for (int p = 9; p < HT; p++) pix(p < HS, 1'b0, pcol(4, p));
    gen_lines(5, VT, -1);
    frame(); frame();
    chk("rst_relock_wait", locked, 0);
    frame();
    chk("rst_relock", locked, 1);
    chk("rst_relock_herr", n_herr - h0, 0);

`ifdef VGA_RX_CRC_EN
    const_rgb = 5;
    frame();
    const_rgb = -1;
    d0 = n_crcv;
    frame();
    chk("crc_valid_cnt", n_crcv - d0, 1);
    chk("frame_crc", frame_crc, crc_model(HA * VA, 8'h05));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
